// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port of mem_arbiter.
// Handshake: a requester raises i_rstrb (or d_rstrb/d_wmask) as a level and holds it
// with stable address/data until it sees its one-cycle done pulse, then drops it on that edge.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_rstrb;
    logic [31:0]           i_rdata;
    logic                  i_done;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_rstrb;
    logic [31:0]           d_wdata;
    logic [3:0]            d_wmask;
    logic [31:0]           d_rdata;
    logic                  d_done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rstrb;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wmask;
    logic [31:0]           mem_rdata;

    modport slave (
        input  i_addr, i_rstrb, d_addr, d_rstrb, d_wdata, d_wmask, mem_rdata,
        output i_rdata, i_done, d_rdata, d_done, mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );

    modport master (
        output i_addr, i_rstrb, d_addr, d_rstrb, d_wdata, d_wmask, mem_rdata,
        input  i_rdata, i_done, d_rdata, d_done, mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the instruction-fetch
// and load/store requesters; sequences read latency and returns data with a done pulse.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic [1:0]    o_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

    localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

    state_t                r_state;
    logic                  r_owner_d;
    logic                  r_last_d;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_cnt;

    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_d_write;
    logic                  w_pick_d;
    logic                  w_grant;
    logic                  w_rd_done;
    logic [ADDR_WIDTH-1:0] w_win_addr;

    assign w_i_req    = bus.i_rstrb;
    assign w_d_write  = |bus.d_wmask;
    assign w_d_req    = w_d_write | bus.d_rstrb;
    // On a tie the port that was not granted last wins.
    assign w_pick_d   = w_d_req & (~w_i_req | ~r_last_d);
    assign w_grant    = (r_state == IDLE) & ~reset & (w_i_req | w_d_req);
    assign w_win_addr = w_pick_d ? bus.d_addr : bus.i_addr;
    assign w_rd_done  = (r_state == READ) & (r_cnt == 4'd0);
    assign o_state    = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner_d <= 1'b0;
            r_last_d  <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner_d <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_addr    <= w_win_addr;
                        r_cnt     <= LAT_INIT;
                        r_state   <= (w_pick_d & w_d_write) ? WRITE : READ;
                    end
                end
                READ: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                    else               r_state <= IDLE;
                end
                WRITE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_addr  = w_grant ? w_win_addr : r_addr;
        bus.mem_rstrb = w_grant & ~(w_pick_d & w_d_write);
        bus.mem_wmask = (w_grant & w_pick_d) ? bus.d_wmask : 4'b0000;
        bus.mem_wdata = bus.d_wdata;
        bus.i_done    = w_rd_done & ~r_owner_d;
        bus.d_done    = (w_rd_done & r_owner_d) | (r_state == WRITE);
        bus.i_rdata   = (w_rd_done & ~r_owner_d) ? bus.mem_rdata : 32'd0;
        bus.d_rdata   = (w_rd_done &  r_owner_d) ? bus.mem_rdata : 32'd0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at READ_LATENCY 1 and 3 with a shared memory model;
// a monitor pops expected {cycle, port, data} entries whenever a done pulse appears.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic sel = 1'b0;  // 0 drives the L=1 instance, 1 the L=3 instance

  logic [49:0] exp_q[$];

  logic [31:0] t_i_addr = '0;
  logic        t_i_rstrb = 1'b0;
  logic [31:0] t_d_addr = '0;
  logic        t_d_rstrb = 1'b0;
  logic [31:0] t_d_wdata = '0;
  logic [3:0]  t_d_wmask = '0;
  logic [1:0]  st1, st3;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus1();
  mem_arbiter_if #(.ADDR_WIDTH(32)) bus3();

  mem_arbiter #(.ADDR_WIDTH(32), .READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1), .o_state(st1));
  mem_arbiter #(.ADDR_WIDTH(32), .READ_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .bus(bus3), .o_state(st3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus1.i_addr  = sel ? '0 : t_i_addr;
  assign bus1.i_rstrb = sel ? 1'b0 : t_i_rstrb;
  assign bus1.d_addr  = sel ? '0 : t_d_addr;
  assign bus1.d_rstrb = sel ? 1'b0 : t_d_rstrb;
  assign bus1.d_wdata = sel ? '0 : t_d_wdata;
  assign bus1.d_wmask = sel ? '0 : t_d_wmask;
  assign bus3.i_addr  = sel ? t_i_addr : '0;
  assign bus3.i_rstrb = sel ? t_i_rstrb : 1'b0;
  assign bus3.d_addr  = sel ? t_d_addr : '0;
  assign bus3.d_rstrb = sel ? t_d_rstrb : 1'b0;
  assign bus3.d_wdata = sel ? t_d_wdata : '0;
  assign bus3.d_wmask = sel ? t_d_wmask : '0;

  logic [31:0] w_i_rdata, w_d_rdata, w_mem_addr, w_mem_wdata;
  logic        w_i_done, w_d_done, w_mem_rstrb;
  logic [3:0]  w_mem_wmask;
  logic [1:0]  w_state;
  assign w_i_rdata   = sel ? bus3.i_rdata : bus1.i_rdata;
  assign w_d_rdata   = sel ? bus3.d_rdata : bus1.d_rdata;
  assign w_i_done    = sel ? bus3.i_done : bus1.i_done;
  assign w_d_done    = sel ? bus3.d_done : bus1.d_done;
  assign w_mem_addr  = sel ? bus3.mem_addr : bus1.mem_addr;
  assign w_mem_rstrb = sel ? bus3.mem_rstrb : bus1.mem_rstrb;
  assign w_mem_wdata = sel ? bus3.mem_wdata : bus1.mem_wdata;
  assign w_mem_wmask = sel ? bus3.mem_wmask : bus1.mem_wmask;
  assign w_state     = sel ? st3 : st1;

  // Memory model: word idx holds C0DE_<idx>, except 0x40 which holds an ADDI opcode.
  logic [31:0] mem [0:255];
  logic [31:0] p1;
  logic [31:0] p3 [0:2];
  assign bus1.mem_rdata = p1;
  assign bus3.mem_rdata = p3[2];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int k = 0; k < 256; k++)
        mem[k] <= (k == 16) ? 32'h0010_0093 : {16'hC0DE, 16'(k)};
    end else begin
      for (int b = 0; b < 4; b++)
        if (w_mem_wmask[b]) mem[w_mem_addr[9:2]][8*b +: 8] <= w_mem_wdata[8*b +: 8];
    end
    p1    <= mem[bus1.mem_addr[9:2]];
    p3[0] <= mem[bus3.mem_addr[9:2]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  function automatic logic [49:0] ent(input int c, input logic is_d, input logic [31:0] d);
    ent = {c[15:0], is_d, ~is_d, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (w_i_done || w_d_done) begin
      logic [49:0] got, e;
      got = {cyc[15:0], w_d_done, w_i_done, w_i_rdata | w_d_rdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got %h with nothing expected", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL done_resp: got cyc=%0d d=%b i=%b data=%h expected cyc=%0d d=%b i=%b data=%h",
                   got[49:34], got[33], got[32], got[31:0], e[49:34], e[33], e[32], e[31:0]);
        end
      end
    end
  end

  task automatic wait_done(input logic is_d);
    int b;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!(is_d ? w_d_done : w_i_done) && b < 40);
    if (!(is_d ? w_d_done : w_i_done)) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no done expected done within 40 cycles", is_d ? "d" : "i");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req_i(input logic [31:0] addr, input int n);
    for (int k = 0; k < n; k++) begin
      t_i_addr  = addr + 32'(4 * k);
      t_i_rstrb = 1'b1;
      wait_done(1'b0);
    end
    t_i_rstrb = 1'b0;
  endtask

  task automatic req_d(input logic [31:0] addr, input int n, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic rstrb);
    for (int k = 0; k < n; k++) begin
      t_d_addr  = addr + 32'(4 * k);
      t_d_wdata = wdata;
      t_d_wmask = wmask;
      t_d_rstrb = rstrb;
      wait_done(1'b1);
    end
    t_d_wmask = 4'b0;
    t_d_rstrb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    // Reset values
    @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(w_state), 32'd0);
    chk("rst_i_done", 32'(w_i_done), 32'd0);
    chk("rst_d_done", 32'(w_d_done), 32'd0);
    chk("rst_mem_rstrb", 32'(w_mem_rstrb), 32'd0);
    chk("rst_mem_wmask", 32'(w_mem_wmask), 32'd0);
    chk("rst_mem_addr", w_mem_addr, 32'd0);
    chk("rst_i_rdata", w_i_rdata, 32'd0);
    chk("rst_d_rdata", w_d_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // I-only read at L=1
    g = cyc;
    exp_q.push_back(ent(g + 1, 1'b0, 32'h0010_0093));
    fork
      req_i(32'h40, 1);
      begin
        @(negedge clk);
        chk("i_only_rstrb", 32'(w_mem_rstrb), 32'd1);
        chk("i_only_addr", w_mem_addr, 32'h40);
      end
    join

    // Simultaneous requests after an I grant: D first, then I
    g = cyc;
    exp_q.push_back(ent(g + 1, 1'b1, 32'hC0DE_0024));
    exp_q.push_back(ent(g + 3, 1'b0, 32'hC0DE_0011));
    fork
      req_d(32'h90, 1, 32'h0, 4'b0, 1'b1);
      req_i(32'h44, 1);
    join

    // Eight continuous contending reads alternate D,I,D,I
    g = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(ent(g + 1 + 4 * k, 1'b1, 32'hC0DE_0020 + 32'(k)));
      exp_q.push_back(ent(g + 3 + 4 * k, 1'b0, 32'hC0DE_0018 + 32'(k)));
    end
    fork
      req_d(32'h80, 4, 32'h0, 4'b0, 1'b1);
      req_i(32'h60, 4);
    join

    // D write of the low half of 0x100
    g = cyc;
    exp_q.push_back(ent(g + 1, 1'b1, 32'h0));
    fork
      req_d(32'h100, 1, 32'hDEAD_BEEF, 4'b0011, 1'b0);
      begin
        @(negedge clk);
        chk("wr_wmask", 32'(w_mem_wmask), 32'h3);
        chk("wr_wdata", w_mem_wdata, 32'hDEAD_BEEF);
        chk("wr_rstrb", 32'(w_mem_rstrb), 32'd0);
        chk("wr_addr", w_mem_addr, 32'h100);
        @(negedge clk);
        chk("wr_wmask_after", 32'(w_mem_wmask), 32'h0);
      end
    join

    // wmask with d_rstrb also set is still a write
    g = cyc;
    exp_q.push_back(ent(g + 1, 1'b1, 32'h0));
    fork
      req_d(32'h104, 1, 32'h1234_5678, 4'b1100, 1'b1);
      begin
        @(negedge clk);
        chk("wr2_rstrb", 32'(w_mem_rstrb), 32'd0);
        chk("wr2_wmask", 32'(w_mem_wmask), 32'hC);
      end
    join

    // Read back both written words
    g = cyc;
    exp_q.push_back(ent(g + 1, 1'b1, 32'hC0DE_BEEF));
    exp_q.push_back(ent(g + 3, 1'b1, 32'h1234_0041));
    req_d(32'h100, 2, 32'h0, 4'b0, 1'b1);

    // READ_LATENCY=3 instance
    sel = 1'b1;
    @(posedge clk);
    #1;
    g = cyc;
    exp_q.push_back(ent(g + 3, 1'b0, 32'hC0DE_0012));
    fork
      req_i(32'h48, 1);
      begin
        @(negedge clk);
        chk("l3_rstrb_g", 32'(w_mem_rstrb), 32'd1);
        chk("l3_addr_g", w_mem_addr, 32'h48);
        for (int k = 1; k < 3; k++) begin
          @(negedge clk);
          chk("l3_rstrb_hold", 32'(w_mem_rstrb), 32'd0);
          chk("l3_addr_hold", w_mem_addr, 32'h48);
        end
        @(negedge clk);
        chk("l3_addr_done", w_mem_addr, 32'h48);
      end
    join

    // Reset during an L=3 read aborts it silently
    t_i_addr  = 32'h4C;
    t_i_rstrb = 1'b1;
    @(negedge clk);
    chk("abort_grant", 32'(w_mem_rstrb), 32'd1);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    t_i_rstrb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_state", 32'(w_state), 32'd0);
    chk("abort_addr", w_mem_addr, 32'd0);
    chk("abort_rstrb", 32'(w_mem_rstrb), 32'd0);
    chk("abort_i_done", 32'(w_i_done), 32'd0);
    @(negedge clk);
    chk("abort_i_rdata", w_i_rdata, 32'd0);
    chk("abort_i_done2", 32'(w_i_done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    g = cyc;
    exp_q.push_back(ent(g + 3, 1'b0, 32'hC0DE_0014));
    req_i(32'h50, 1);

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
